// File: rtl/benes_8p_fabric_pkg.sv
// Shared constants and configuration-bit indexing for the 8-port Benes fabric.
package benes_8p_fabric_pkg;

   localparam int NUM_PORTS = 8;
   localparam int NUM_COLS  = 5;
   localparam int NUM_ROWS  = 4;
   localparam int CFG_W     = 20;

   // Switch at (row, col) is controlled by cfg bit 5*row + col.
   function automatic int cfg_bit_idx(input int row, input int col);
      return NUM_COLS * row + col;
   endfunction

endpackage

// File: rtl/benes_8p_fabric_sw2x2.sv
// Combinational 2x2 exchange element: sel=1 passes straight, sel=0 crosses.
module benes_sw2x2
   import benes_8p_fabric_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              sel,
   input  logic [DATA_W-1:0] in0,
   input  logic [DATA_W-1:0] in1,
   output logic [DATA_W-1:0] out0,
   output logic [DATA_W-1:0] out1
);

   assign out0 = sel ? in0 : in1;
   assign out1 = sel ? in1 : in0;

endmodule

// File: rtl/benes_8p_fabric.sv
// Five-column 8-port Benes permutation fabric, one register stage per column,
// with the switch configuration snapshotted per beat at acceptance.
module benes_8p_fabric
   import benes_8p_fabric_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        cfg_valid,
   input  logic [CFG_W-1:0]            cfg_state,
   output logic                        cfg_ack,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [NUM_PORTS*DATA_W-1:0] in_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [NUM_PORTS*DATA_W-1:0] out_data
);

   logic [CFG_W-1:0]        active_cfg;
   logic [NUM_ROWS-1:0]     col_sel [NUM_COLS];
   logic [4*NUM_ROWS-1:0]   cfg_rest;
   logic [4*NUM_ROWS-1:0]   snap0;
   logic [3*NUM_ROWS-1:0]   snap1;
   logic [2*NUM_ROWS-1:0]   snap2;
   logic [NUM_ROWS-1:0]     snap3;
   logic [DATA_W-1:0]       col_in  [NUM_COLS][NUM_PORTS];
   logic [DATA_W-1:0]       col_out [NUM_COLS][NUM_PORTS];
   logic [DATA_W-1:0]       st_data [NUM_COLS][NUM_PORTS];
   logic [NUM_COLS-1:0]     st_valid;
   logic                    enable;

   assign enable    = !out_valid || out_ready;
   assign in_ready  = enable;
   assign out_valid = st_valid[NUM_COLS-1];

   // Snapshot is column-major so each stage peels off its low NUM_ROWS bits
   // and hands the remaining columns on to the next stage.
   for (genvar r = 0; r < NUM_ROWS; r++) begin : g_sel
      assign col_sel[0][r] = active_cfg[cfg_bit_idx(r, 0)];
      for (genvar c = 1; c < NUM_COLS; c++) begin : g_rest
         assign cfg_rest[(c-1)*NUM_ROWS + r] = active_cfg[cfg_bit_idx(r, c)];
      end
      assign col_sel[1][r] = snap0[r];
      assign col_sel[2][r] = snap1[r];
      assign col_sel[3][r] = snap2[r];
      assign col_sel[4][r] = snap3[r];
   end

   // Inter-column wiring, expressed as lane positions 2*row+port in each column.
   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_wire
      assign col_in[0][p] = in_data[p*DATA_W +: DATA_W];
      assign col_in[1][p] = st_data[0][2*(p%4) + p/4];
      assign col_in[2][p] = st_data[1][(p/4)*4 + 2*(p%2) + (p/2)%2];
      assign col_in[3][p] = st_data[2][(p/4)*4 + 2*(p%2) + (p/2)%2];
      assign col_in[4][p] = st_data[3][4*(p%2) + p/2];
      assign out_data[p*DATA_W +: DATA_W] = st_data[NUM_COLS-1][p];
   end

   for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
      for (genvar m = 0; m < NUM_ROWS; m++) begin : g_row
         benes_sw2x2 #(.DATA_W(DATA_W)) u_sw (
            .sel  (col_sel[c][m]),
            .in0  (col_in[c][2*m]),
            .in1  (col_in[c][2*m+1]),
            .out0 (col_out[c][2*m]),
            .out1 (col_out[c][2*m+1])
         );
      end
   end

   // Config loads are never blocked by a stall; the pipeline moves only on enable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_cfg <= '1;
         cfg_ack    <= 1'b0;
         st_valid   <= '0;
         snap0      <= '1;
         snap1      <= '1;
         snap2      <= '1;
         snap3      <= '1;
         for (int s = 0; s < NUM_COLS; s++) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
               st_data[s][p] <= '0;
            end
         end
      end else begin
         cfg_ack <= cfg_valid;
         if (cfg_valid) begin
            active_cfg <= cfg_state;
         end
         if (enable) begin
            st_valid <= {st_valid[NUM_COLS-2:0], in_valid};
            snap0    <= cfg_rest;
            snap1    <= snap0[4*NUM_ROWS-1:NUM_ROWS];
            snap2    <= snap1[3*NUM_ROWS-1:NUM_ROWS];
            snap3    <= snap2[2*NUM_ROWS-1:NUM_ROWS];
            for (int s = 0; s < NUM_COLS; s++) begin
               for (int p = 0; p < NUM_PORTS; p++) begin
                  st_data[s][p] <= col_out[s][p];
               end
            end
         end
      end
   end

endmodule
